gemm_tile_streamer: RTL and testbench

//  Read-side DMA stage placed directly upstream of the GEMM byte memory. It walks a

---
 rtl/gemm_stream_pkg.sv | 13 +
 rtl/gemm_chunk_fifo.sv | 45 ++++
 rtl/gemm_tile_streamer.sv | 151 +++++++++++++++
 tb/tb_gemm_tile_streamer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_stream_pkg.sv
// Shared types for the GEMM tile read streamer: FSM states and the buffered chunk record.
package gemm_stream_pkg;
   localparam int CHUNK_BYTES = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stream_state_e;

   typedef struct packed {
      logic [8*CHUNK_BYTES-1:0] data;
      logic [4:0]               bytes;
      logic                     row_last;
      logic                     tile_last;
   } chunk_t;
endpackage

// File: rtl/gemm_chunk_fifo.sv
// Synchronous chunk FIFO; a push is accepted while full when a pop happens in the same cycle.
module gemm_chunk_fifo
   import gemm_stream_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  chunk_t din,
   output chunk_t dout,
   output logic   full,
   output logic   empty
);
   localparam int PW = $clog2(DEPTH);

   chunk_t      mem_q [DEPTH];
   logic [PW:0] wr_ptr_q;
   logic [PW:0] rd_ptr_q;
   logic        do_push;
   logic        do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q[PW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
   end
endmodule

// File: rtl/gemm_tile_streamer.sv
// Walks a matrix tile row by row, issues masked 16-byte reads and streams chunks out.
// Define GEMM_STREAM_PERF_EN to add the stall and chunk performance counters.
module gemm_tile_streamer
   import gemm_stream_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int DIM_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [DIM_W-1:0]  cfg_rows,
   input  logic [DIM_W-1:0]  cfg_row_bytes,
   input  logic [ADDR_W-1:0] cfg_stride,
   output logic              busy,
   output logic              done,
   output logic              interface_en,
   output logic              interface_rdwr,
   output logic [ADDR_W-1:0] interface_addr,
   output logic [4:0]        interface_control,
   output logic [127:0]      interface_wr_data,
   input  logic [127:0]      interface_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_data,
   output logic [4:0]        out_bytes,
   output logic              out_row_last,
   output logic              out_tile_last
`ifdef GEMM_STREAM_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_chunks
`endif
);
   localparam logic [DIM_W-1:0] CHUNK_DIM = DIM_W'(CHUNK_BYTES);

   stream_state_e     state_q, state_d;
   logic [DIM_W-1:0]  rows_q, row_bytes_q, row_idx_q, off_q, remaining;
   logic [ADDR_W-1:0] stride_q, row_addr_q;
   logic              start_ok, zero_cmd, pop, row_last, tile_last;
   logic              fifo_full, fifo_empty;
   logic [4:0]        chunk_ctl;
   chunk_t            push_chunk, head;

   assign start_ok  = start && (state_q == IDLE);
   assign zero_cmd  = (cfg_rows == '0) || (cfg_row_bytes == '0);
   assign remaining = row_bytes_q - off_q;
   assign chunk_ctl = (remaining >= CHUNK_DIM) ? 5'd16 : remaining[4:0];
   assign row_last  = (remaining <= CHUNK_DIM);
   assign tile_last = row_last && (row_idx_q == rows_q - DIM_W'(1));
   assign pop       = out_valid && out_ready;

   assign interface_en      = (state_q == ISSUE) && (!fifo_full || pop);
   assign interface_rdwr    = 1'b0;
   assign interface_wr_data = '0;
   assign interface_addr    = interface_en ? row_addr_q + ADDR_W'(off_q) : '0;
   assign interface_control = interface_en ? chunk_ctl : '0;

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   // Bytes past the chunk's valid count are forced to zero before buffering.
   always_comb begin
      push_chunk           = '0;
      push_chunk.bytes     = chunk_ctl;
      push_chunk.row_last  = row_last;
      push_chunk.tile_last = tile_last;
      for (int k = 0; k < CHUNK_BYTES; k++) begin
         if (5'(k) < chunk_ctl) push_chunk.data[k*8 +: 8] = interface_rd_data[k*8 +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = zero_cmd ? DONE : ISSUE;
         ISSUE:   if (interface_en && tile_last) state_d = DRAIN;
         DRAIN:   if (fifo_empty) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rows_q      <= '0;
         row_bytes_q <= '0;
         stride_q    <= '0;
         row_addr_q  <= '0;
         row_idx_q   <= '0;
         off_q       <= '0;
      end else if (start_ok) begin
         rows_q      <= cfg_rows;
         row_bytes_q <= cfg_row_bytes;
         stride_q    <= cfg_stride;
         row_addr_q  <= cfg_base;
         row_idx_q   <= '0;
         off_q       <= '0;
      end else if (interface_en) begin
         if (row_last) begin
            row_idx_q  <= row_idx_q + DIM_W'(1);
            row_addr_q <= row_addr_q + stride_q;
            off_q      <= '0;
         end else begin
            off_q <= off_q + CHUNK_DIM;
         end
      end
   end

   gemm_chunk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (interface_en),
      .pop   (pop),
      .din   (push_chunk),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid     = !fifo_empty;
   assign out_data      = head.data;
   assign out_bytes     = head.bytes;
   assign out_row_last  = head.row_last;
   assign out_tile_last = head.tile_last;

`ifdef GEMM_STREAM_PERF_EN
   logic stall_evt;
   assign stall_evt = (state_q == ISSUE) && fifo_full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_chunks       <= '0;
      end else if (start_ok) begin
         perf_stall_cycles <= '0;
         perf_chunks       <= '0;
      end else begin
         if (stall_evt && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (interface_en && !(&perf_chunks))    perf_chunks       <= perf_chunks + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_gemm_tile_streamer.sv
// Directed bench for gemm_tile_streamer against a 2000-byte memory holding mem[i]=i[7:0].
module tb_gemm_tile_streamer;
   localparam int ADDR_W = 32, DIM_W = 8, FIFO_DEPTH = 4, MEM_BYTES = 2000;

   logic              clk, rst, start;
   logic [ADDR_W-1:0] cfg_base, cfg_stride;
   logic [DIM_W-1:0]  cfg_rows, cfg_row_bytes;
   logic              busy, done, interface_en, interface_rdwr;
   logic [ADDR_W-1:0] interface_addr;
   logic [4:0]        interface_control, out_bytes;
   logic [127:0]      interface_wr_data, interface_rd_data, out_data;
   logic              out_valid, out_ready, out_row_last, out_tile_last;
`ifdef GEMM_STREAM_PERF_EN
   logic [31:0]       perf_stall_cycles, perf_chunks;
`endif

   gemm_tile_streamer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .DIM_W(DIM_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_base(cfg_base), .cfg_rows(cfg_rows), .cfg_row_bytes(cfg_row_bytes), .cfg_stride(cfg_stride),
      .busy(busy), .done(done),
      .interface_en(interface_en), .interface_rdwr(interface_rdwr), .interface_addr(interface_addr),
      .interface_control(interface_control), .interface_wr_data(interface_wr_data),
      .interface_rd_data(interface_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bytes(out_bytes),
      .out_row_last(out_row_last), .out_tile_last(out_tile_last)
`ifdef GEMM_STREAM_PERF_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_chunks(perf_chunks)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [MEM_BYTES];
   always_comb begin
      interface_rd_data = '0;
      for (int k = 0; k < 16; k++) begin
         if (interface_addr < 32'(MEM_BYTES - k))
            interface_rd_data[k*8 +: 8] = mem[interface_addr + 32'(k)];
      end
   end

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Observation log, captured on the falling edge.
   int           cyc = 0, pop_cyc, done_cyc, done_cnt, busy_cnt;
   logic [31:0]  iss_addr [$];
   logic [4:0]   iss_ctl [$];
   logic [127:0] got_data [$];
   logic [4:0]   got_bytes [$];
   logic         got_rl [$], got_tl [$];
   logic         prev_hold = 1'b0;
   logic [127:0] prev_data;
   logic [6:0]   prev_meta;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (prev_hold && out_valid && !rst) begin
         chk("hold_data", out_data, prev_data);
         chk("hold_meta", {out_bytes, out_row_last, out_tile_last}, prev_meta);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_meta = {out_bytes, out_row_last, out_tile_last};
      if (interface_en) begin
         iss_addr.push_back(interface_addr);
         iss_ctl.push_back(interface_control);
      end
      if (out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_bytes.push_back(out_bytes);
         got_rl.push_back(out_row_last);
         got_tl.push_back(out_tile_last);
         pop_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
   end

   int   ex_addr [$], ex_ctl [$];
   logic ex_rl [$], ex_tl [$];

   task automatic clear_log();
      iss_addr.delete(); iss_ctl.delete(); got_data.delete(); got_bytes.delete();
      got_rl.delete(); got_tl.delete();
      ex_addr.delete(); ex_ctl.delete(); ex_rl.delete(); ex_tl.delete();
      done_cnt = 0; busy_cnt = 0;
   endtask

   task automatic add_exp(input int a, input int c, input logic rl, input logic tl);
      ex_addr.push_back(a); ex_ctl.push_back(c); ex_rl.push_back(rl); ex_tl.push_back(tl);
   endtask

   function automatic logic [127:0] exp_chunk(input int a, input int n);
      logic [127:0] d = '0;
      for (int k = 0; k < n; k++) d[k*8 +: 8] = 8'((a + k) & 255);
      return d;
   endfunction

   task automatic check_chunks(input string tag);
      chk({tag, "_n_issue"}, iss_addr.size(), ex_addr.size());
      chk({tag, "_n_pop"}, got_data.size(), ex_addr.size());
      for (int i = 0; i < ex_addr.size(); i++) begin
         if (i < iss_addr.size()) begin
            chk($sformatf("%s_addr%0d", tag, i), iss_addr[i], ex_addr[i]);
            chk($sformatf("%s_ctl%0d", tag, i), iss_ctl[i], ex_ctl[i]);
         end
         if (i < got_data.size()) begin
            chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_chunk(ex_addr[i], ex_ctl[i]));
            chk($sformatf("%s_bytes%0d", tag, i), got_bytes[i], ex_ctl[i]);
            chk($sformatf("%s_rl%0d", tag, i), got_rl[i], ex_rl[i]);
            chk($sformatf("%s_tl%0d", tag, i), got_tl[i], ex_tl[i]);
         end
      end
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [7:0] rows,
                              input logic [7:0] rb, input logic [31:0] stride);
      @(posedge clk); #1;
      cfg_base = base; cfg_rows = rows; cfg_row_bytes = rb; cfg_stride = stride;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int i = 0;
      while (done_cnt == 0 && i < 300) begin
         @(posedge clk); #1;
         i++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_once"}, done_cnt, 1);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = i[7:0];
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      cfg_base = '0; cfg_rows = '0; cfg_row_bytes = '0; cfg_stride = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", interface_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_addr", interface_addr, 0);
      chk("rst_ctl", interface_control, 0);
      rst = 1'b0;

      // 1: single full chunk
      clear_log();
      add_exp(32'h10, 16, 1, 1);
      pulse_start(32'h10, 1, 16, 0);
      wait_done("t1");
      check_chunks("t1");
      chk("t1_done_gap", done_cyc - pop_cyc, 2);
      chk("t1_rdwr", interface_rdwr, 0);
      chk("t1_wrdata", interface_wr_data, 0);

      // 2: partial trailing chunks with stride
      clear_log();
      add_exp(0, 16, 0, 0); add_exp(16, 4, 1, 0); add_exp(64, 16, 0, 0); add_exp(80, 4, 1, 1);
      pulse_start(0, 2, 20, 64);
      wait_done("t2");
      check_chunks("t2");

      // 3: backpressure fills the FIFO
      clear_log();
      for (int r = 0; r < 3; r++)
         for (int o = 0; o < 48; o += 16)
            add_exp(32'h100 + r * 64 + o, 16, o == 32, (o == 32) && (r == 2));
      out_ready = 1'b0;
      pulse_start(32'h100, 3, 48, 64);
      repeat (10) @(posedge clk);
      #1;
      chk("t3_pushes_stalled", iss_addr.size(), FIFO_DEPTH);
      chk("t3_en_low", interface_en, 0);
      chk("t3_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_done("t3");
      check_chunks("t3");
`ifdef GEMM_STREAM_PERF_EN
      chk("t3_perf_stall_nz", perf_stall_cycles != 0, 1);
      chk("t3_perf_chunks", perf_chunks, 9);
`endif

      // 4: zero-size command
      clear_log();
      pulse_start(32'h40, 0, 16, 16);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_no_access", iss_addr.size(), 0);
      chk("t4_done_once", done_cnt, 1);
      chk("t4_busy_seen", busy_cnt != 0, 1);
      chk("t4_idle", busy, 0);

      // 5: asynchronous reset mid-ISSUE, then a clean tile
      clear_log();
      out_ready = 1'b0;
      pulse_start(0, 4, 64, 64);
      repeat (2) @(posedge clk);
      #1;
      chk("t5_valid_before", out_valid, 1);
      chk("t5_busy_before", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_valid_rst", out_valid, 0);
      chk("t5_busy_rst", busy, 0);
      chk("t5_en_rst", interface_en, 0);
      #3 rst = 1'b0;
      chk("t5_no_done", done_cnt, 0);
      clear_log();
      out_ready = 1'b1;
      add_exp(32'h10, 16, 1, 1);
      pulse_start(32'h10, 1, 16, 0);
      wait_done("t5b");
      check_chunks("t5b");

      // 6: re-pulsed start while busy is ignored
      clear_log();
      add_exp(32'h200, 16, 0, 0); add_exp(32'h210, 16, 1, 1);
      out_ready = 1'b0;
      pulse_start(32'h200, 1, 32, 0);
      pulse_start(32'h300, 2, 16, 16);
      out_ready = 1'b1;
      wait_done("t6");
      check_chunks("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
